// File: rtl/cgra_x_heep_pkg.sv
// Shared CGRA/X-HEEP constants and the context-port response state type.
package cgra_x_heep_pkg;

   localparam logic [31:0] CGRA_START_ADDRESS = 32'hF000_0000;
   localparam logic [31:0] CGRA_SIZE          = 32'h0010_0000;
   localparam logic [31:0] CGRA_ERR_RDATA     = 32'hBADA_CCE5;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RSP_MEM = 2'd1,
      RSP_ERR = 2'd2
   } cgra_rsp_state_e;

endpackage

// File: rtl/cgra_obi_addr_chk.sv
// Window decode for the CGRA context port: range check and memory word address.
module cgra_obi_addr_chk
   import cgra_x_heep_pkg::*;
#(
   parameter logic [31:0] START_ADDR = CGRA_START_ADDRESS,
   parameter logic [31:0] SIZE       = CGRA_SIZE,
   parameter int unsigned MEM_AW     = 18
) (
   input  logic [31:0]       addr_i,
   output logic              in_range_o,
   output logic [MEM_AW-1:0] word_addr_o
);

   logic [31:0] offset_s;

   // Comparing the offset against SIZE avoids overflow of START_ADDR+SIZE.
   always_comb begin
      offset_s    = addr_i - START_ADDR;
      in_range_o  = (addr_i >= START_ADDR) && (offset_s < SIZE);
      word_addr_o = offset_s[MEM_AW+1:2];
   end

endmodule

// File: rtl/cgra_ctx_obi_resp.sv
// OBI slave front-end for the CGRA context memory with error responses.
// Optional error counter enabled by macro CGRA_CTX_OBI_RESP_ERR_CNT_EN.
module cgra_ctx_obi_resp
   import cgra_x_heep_pkg::*;
#(
   parameter logic [31:0] START_ADDR = CGRA_START_ADDRESS,
   parameter logic [31:0] SIZE       = CGRA_SIZE,
   parameter int unsigned MEM_AW     = 18
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              req_i,
   input  logic              we_i,
   input  logic [3:0]        be_i,
   input  logic [31:0]       addr_i,
   input  logic [31:0]       wdata_i,
   output logic              gnt_o,
   output logic              rvalid_o,
   output logic [31:0]       rdata_o,
   output logic              mem_req_o,
   output logic              mem_we_o,
   output logic [3:0]        mem_be_o,
   output logic [MEM_AW-1:0] mem_addr_o,
   output logic [31:0]       mem_wdata_o,
   input  logic [31:0]       mem_rdata_i,
   input  logic              mem_ready_i,
   input  logic              err_clr_i,
   output logic [15:0]       err_cnt_o
);

   cgra_rsp_state_e   state_r, state_next_s;
   logic              we_r;
   logic              in_range_s;
   logic              gnt_s;
   logic              err_gnt_s;
   logic [MEM_AW-1:0] word_addr_s;

   cgra_obi_addr_chk #(
      .START_ADDR (START_ADDR),
      .SIZE       (SIZE),
      .MEM_AW     (MEM_AW)
   ) u_addr_chk (
      .addr_i      (addr_i),
      .in_range_o  (in_range_s),
      .word_addr_o (word_addr_s)
   );

   // Grant, memory request and next response type; all suppressed in reset.
   always_comb begin
      gnt_s        = 1'b0;
      err_gnt_s    = 1'b0;
      state_next_s = IDLE;
      if (rst_ni) begin
         gnt_s     = req_i && (mem_ready_i || !in_range_s);
         err_gnt_s = gnt_s && !in_range_s;
         if (gnt_s) begin
            state_next_s = in_range_s ? RSP_MEM : RSP_ERR;
         end else begin
            state_next_s = IDLE;
         end
      end else begin
         gnt_s        = 1'b0;
         err_gnt_s    = 1'b0;
         state_next_s = IDLE;
      end
      gnt_o       = gnt_s;
      mem_req_o   = gnt_s && in_range_s;
      mem_we_o    = we_i;
      mem_be_o    = be_i;
      mem_wdata_o = wdata_i;
      mem_addr_o  = word_addr_s;
   end

   // Response state register.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_r <= IDLE;
         we_r    <= 1'b0;
      end else begin
         state_r <= state_next_s;
         we_r    <= we_i;
      end
   end

   // Response mux; gating with rst_ni drops a response due while reset is held.
   always_comb begin
      rvalid_o = 1'b0;
      rdata_o  = 32'h0;
      if (rst_ni) begin
         case (state_r)
            RSP_MEM: begin
               rvalid_o = 1'b1;
               rdata_o  = we_r ? 32'h0 : mem_rdata_i;
            end
            RSP_ERR: begin
               rvalid_o = 1'b1;
               rdata_o  = we_r ? 32'h0 : CGRA_ERR_RDATA;
            end
            IDLE: begin
               rvalid_o = 1'b0;
               rdata_o  = 32'h0;
            end
            default: begin
               rvalid_o = 1'b0;
               rdata_o  = 32'h0;
            end
         endcase
      end else begin
         rvalid_o = 1'b0;
         rdata_o  = 32'h0;
      end
   end

`ifdef CGRA_CTX_OBI_RESP_ERR_CNT_EN
   logic [15:0] err_cnt_r;

   // Saturating out-of-range counter; a clear coinciding with an error grant counts it.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         err_cnt_r <= 16'h0;
      end else if (err_clr_i) begin
         err_cnt_r <= err_gnt_s ? 16'h1 : 16'h0;
      end else if (err_gnt_s && (err_cnt_r != 16'hFFFF)) begin
         err_cnt_r <= err_cnt_r + 16'h1;
      end else begin
         err_cnt_r <= err_cnt_r;
      end
   end

   assign err_cnt_o = err_cnt_r;
`else
   logic err_clr_unused_s;
   logic err_gnt_unused_s;

   assign err_clr_unused_s = err_clr_i;
   assign err_gnt_unused_s = err_gnt_s;
   assign err_cnt_o        = 16'h0;
`endif

endmodule

// File: tb/tb_cgra_ctx_obi_resp.sv
// Directed bench for cgra_ctx_obi_resp: vector table plus stall, burst and reset sequences.
module tb_cgra_ctx_obi_resp;
   import cgra_x_heep_pkg::*;

   localparam logic [31:0] S   = 32'hF000_0000;
   localparam logic [31:0] E   = 32'hF010_0000;
   localparam logic [31:0] BAD = 32'hBADA_CCE5;

   logic        clk_i = 1'b0;
   logic        rst_ni = 1'b0;
   logic        req_i = 1'b0, we_i = 1'b0, mem_ready_i = 1'b0, err_clr_i = 1'b0;
   logic [3:0]  be_i = 4'h0;
   logic [31:0] addr_i = 32'h0, wdata_i = 32'h0, mem_rdata_i = 32'h0;
   logic        gnt_o, rvalid_o, mem_req_o, mem_we_o;
   logic [31:0] rdata_o, mem_wdata_o;
   logic [3:0]  mem_be_o;
   logic [17:0] mem_addr_o;
   logic [15:0] err_cnt_o;

   int n_chk = 0;
   int n_fail = 0;

   always #5 clk_i = ~clk_i;

   cgra_ctx_obi_resp dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i), .we_i(we_i), .be_i(be_i),
      .addr_i(addr_i), .wdata_i(wdata_i), .gnt_o(gnt_o), .rvalid_o(rvalid_o),
      .rdata_o(rdata_o), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
      .mem_be_o(mem_be_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
      .mem_rdata_i(mem_rdata_i), .mem_ready_i(mem_ready_i),
      .err_clr_i(err_clr_i), .err_cnt_o(err_cnt_o)
   );

   typedef struct {
      logic        req;
      logic        we;
      logic [3:0]  be;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        ready;
      logic [31:0] mrdata;
      logic        clr;
      logic        e_gnt;
      logic        e_mreq;
      logic [17:0] e_maddr;
      logic        e_rvalid;
      logic [31:0] e_rdata;
      logic [15:0] e_err;
   } vec_t;

   vec_t vec [14];

   function automatic logic [15:0] ecnt(input logic [15:0] v);
`ifdef CGRA_CTX_OBI_RESP_ERR_CNT_EN
      return v;
`else
      return 16'h0 & v;
`endif
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic req, input logic we, input logic [31:0] addr,
                        input logic ready, input logic [31:0] mrdata, input logic clr);
      req_i = req; we_i = we; addr_i = addr; be_i = 4'hF; wdata_i = 32'hCAFE_0000;
      mem_ready_i = ready; mem_rdata_i = mrdata; err_clr_i = clr;
   endtask

   task automatic next_cycle();
      @(posedge clk_i);
      #1;
   endtask

   initial begin
      vec[0]  = '{1'b0, 1'b0, 4'hF, S,            32'h0,         1'b1, 32'h0,         1'b0, 1'b0, 1'b0, 18'h0,     1'b0, 32'h0,         16'd0};
      vec[1]  = '{1'b1, 1'b1, 4'hF, S + 32'h10,   32'hDEAD_BEEF, 1'b1, 32'h0,         1'b0, 1'b1, 1'b1, 18'h4,     1'b0, 32'h0,         16'd0};
      vec[2]  = '{1'b1, 1'b0, 4'h3, S + 32'h10,   32'h0,         1'b1, 32'h7777_7777, 1'b0, 1'b1, 1'b1, 18'h4,     1'b1, 32'h0,         16'd0};
      vec[3]  = '{1'b1, 1'b0, 4'hF, E,            32'h0,         1'b1, 32'h1234_5678, 1'b0, 1'b1, 1'b0, 18'h0,     1'b1, 32'h1234_5678, 16'd0};
      vec[4]  = '{1'b0, 1'b0, 4'hF, 32'hF00F_FFFC, 32'h0,        1'b1, 32'h5555_5555, 1'b0, 1'b0, 1'b0, 18'h3FFFF, 1'b1, BAD,           16'd1};
      vec[5]  = '{1'b1, 1'b0, 4'hF, 32'hF00F_FFFC, 32'h0,        1'b1, 32'h0,         1'b0, 1'b1, 1'b1, 18'h3FFFF, 1'b0, 32'h0,         16'd1};
      vec[6]  = '{1'b0, 1'b0, 4'hF, 32'h0,        32'h0,         1'b1, 32'hA5A5_0001, 1'b0, 1'b0, 1'b0, 18'h0,     1'b1, 32'hA5A5_0001, 16'd1};
      vec[7]  = '{1'b1, 1'b0, 4'hF, 32'hEFFF_FFFC, 32'h0,        1'b0, 32'h0,         1'b0, 1'b1, 1'b0, 18'h3FFFF, 1'b0, 32'h0,         16'd1};
      vec[8]  = '{1'b1, 1'b1, 4'hF, S + 32'h8,    32'h0000_00AB, 1'b0, 32'h6666_6666, 1'b0, 1'b0, 1'b0, 18'h2,     1'b1, BAD,           16'd2};
      vec[9]  = '{1'b1, 1'b1, 4'hC, S + 32'h8,    32'h0000_00AB, 1'b1, 32'h0,         1'b0, 1'b1, 1'b1, 18'h2,     1'b0, 32'h0,         16'd2};
      vec[10] = '{1'b1, 1'b1, 4'hF, E,            32'h0,         1'b1, 32'h9999_9999, 1'b1, 1'b1, 1'b0, 18'h0,     1'b1, 32'h0,         16'd2};
      vec[11] = '{1'b0, 1'b0, 4'hF, S,            32'h0,         1'b1, 32'h0,         1'b0, 1'b0, 1'b0, 18'h0,     1'b1, 32'h0,         16'd1};
      vec[12] = '{1'b0, 1'b0, 4'hF, S,            32'h0,         1'b1, 32'h0,         1'b1, 1'b0, 1'b0, 18'h0,     1'b0, 32'h0,         16'd1};
      vec[13] = '{1'b0, 1'b0, 4'hF, S,            32'h0,         1'b1, 32'h0,         1'b0, 1'b0, 1'b0, 18'h0,     1'b0, 32'h0,         16'd0};

      // Reset with an in-range request pending: nothing may be granted.
      drive(1'b1, 1'b0, S + 32'h10, 1'b1, 32'h0, 1'b0);
      repeat (3) next_cycle();
      @(negedge clk_i);
      chk("rst_gnt", {31'h0, gnt_o}, 32'h0);
      chk("rst_mreq", {31'h0, mem_req_o}, 32'h0);
      chk("rst_rvalid", {31'h0, rvalid_o}, 32'h0);
      chk("rst_rdata", rdata_o, 32'h0);
      chk("rst_err", {16'h0, err_cnt_o}, 32'h0);
      drive(1'b0, 1'b0, S, 1'b1, 32'h0, 1'b0);
      next_cycle();
      rst_ni = 1'b1;

      for (int i = 0; i < 14; i++) begin
         req_i = vec[i].req; we_i = vec[i].we; be_i = vec[i].be; addr_i = vec[i].addr;
         wdata_i = vec[i].wdata; mem_ready_i = vec[i].ready; mem_rdata_i = vec[i].mrdata;
         err_clr_i = vec[i].clr;
         @(negedge clk_i);
         chk($sformatf("v%0d_gnt", i), {31'h0, gnt_o}, {31'h0, vec[i].e_gnt});
         chk($sformatf("v%0d_mreq", i), {31'h0, mem_req_o}, {31'h0, vec[i].e_mreq});
         chk($sformatf("v%0d_maddr", i), {14'h0, mem_addr_o}, {14'h0, vec[i].e_maddr});
         chk($sformatf("v%0d_rvalid", i), {31'h0, rvalid_o}, {31'h0, vec[i].e_rvalid});
         chk($sformatf("v%0d_rdata", i), rdata_o, vec[i].e_rdata);
         chk($sformatf("v%0d_err", i), {16'h0, err_cnt_o}, {16'h0, ecnt(vec[i].e_err)});
         if (vec[i].e_mreq) begin
            chk($sformatf("v%0d_mwe", i), {31'h0, mem_we_o}, {31'h0, vec[i].we});
            chk($sformatf("v%0d_mbe", i), {28'h0, mem_be_o}, {28'h0, vec[i].be});
            chk($sformatf("v%0d_mwdata", i), mem_wdata_o, vec[i].wdata);
         end
         next_cycle();
      end

      // Stall three cycles on mem_ready_i=0, grant on the fourth, exactly one response.
      for (int c = 0; c < 4; c++) begin
         drive(1'b1, 1'b0, S + 32'h40, (c == 3), 32'h0, 1'b0);
         @(negedge clk_i);
         chk($sformatf("stall%0d_gnt", c), {31'h0, gnt_o}, {31'h0, (c == 3)});
         chk($sformatf("stall%0d_rvalid", c), {31'h0, rvalid_o}, 32'h0);
         next_cycle();
      end
      drive(1'b0, 1'b0, S, 1'b1, 32'h0BAD_F00D, 1'b0);
      @(negedge clk_i);
      chk("stall_rsp_valid", {31'h0, rvalid_o}, 32'h1);
      chk("stall_rsp_data", rdata_o, 32'h0BAD_F00D);
      next_cycle();
      @(negedge clk_i);
      chk("stall_rsp_single", {31'h0, rvalid_o}, 32'h0);
      next_cycle();

      // Four back-to-back grants alternating in/out of range, clear with the second.
      begin
         logic [31:0] b_addr [4];
         logic [31:0] b_mem  [5];
         logic [31:0] b_exp  [5];
         b_addr = '{S + 32'h20, E + 32'h100, S + 32'h24, 32'h0000_1000};
         b_mem  = '{32'h0, 32'h0000_1111, 32'h0, 32'h0000_2222, 32'h0};
         b_exp  = '{32'h0, 32'h0000_1111, BAD, 32'h0000_2222, BAD};
         for (int c = 0; c < 6; c++) begin
            if (c < 4) drive(1'b1, 1'b0, b_addr[c], 1'b1, (c < 5) ? b_mem[c] : 32'h0, (c == 1));
            else drive(1'b0, 1'b0, S, 1'b1, (c < 5) ? b_mem[c] : 32'h0, 1'b0);
            @(negedge clk_i);
            if (c < 4) chk($sformatf("b2b%0d_gnt", c), {31'h0, gnt_o}, 32'h1);
            chk($sformatf("b2b%0d_rvalid", c), {31'h0, rvalid_o}, {31'h0, (c >= 1 && c <= 4)});
            if (c >= 1 && c <= 4) chk($sformatf("b2b%0d_rdata", c), rdata_o, b_exp[c]);
            next_cycle();
         end
         @(negedge clk_i);
         chk("b2b_err_after_clr", {16'h0, err_cnt_o}, {16'h0, ecnt(16'd2)});
         next_cycle();
      end

      // Grant, then reset the next cycle: the pending response must vanish.
      drive(1'b1, 1'b0, E, 1'b1, 32'h0, 1'b0);
      next_cycle();
      drive(1'b1, 1'b0, S + 32'h30, 1'b1, 32'h3333_3333, 1'b0);
      next_cycle();
      drive(1'b0, 1'b0, S, 1'b1, 32'h4444_4444, 1'b0);
      rst_ni = 1'b0;
      @(negedge clk_i);
      chk("rst_drop_rvalid", {31'h0, rvalid_o}, 32'h0);
      chk("rst_drop_rdata", rdata_o, 32'h0);
      next_cycle();
      rst_ni = 1'b1;
      for (int c = 0; c < 2; c++) begin
         @(negedge clk_i);
         chk($sformatf("post_rst%0d_rvalid", c), {31'h0, rvalid_o}, 32'h0);
         chk($sformatf("post_rst%0d_err", c), {16'h0, err_cnt_o}, 32'h0);
         next_cycle();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
